// File: rtl/lead0_normalize64.sv
// lead0_normalize64 -- normalizing shifter placed after the 64-bit LZD in the
// ICDF Gaussian generator. It left-justifies the 61-bit uniform word using the
// leading-zero count from the LZD, so bit 60 of norm_out is the leading one.
//
// Build option: define NORM_PIPELINE_EN for a three-stage 16/4/1 shifter with
// 4-cycle latency. Leave it undefined for a single barrel shift with 2-cycle
// latency. Both builds have identical outputs, reset values and valid behaviour.
//
// Counts 62/63 never come from the LZD. If one arrives anyway, the total shift
// is at least 61, so every bit leaves the 61-bit window and norm_out becomes 0.
// zero_flag stays low because it only matches 61. lz_out passes the count through.

module lead0_normalize64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_norm,
    input  logic [60:0] in,
    input  logic [5:0]  zero_pos,
    output logic [60:0] norm_out,
    output logic [5:0]  lz_out,
    output logic        zero_flag,
    output logic        valid_out
);

    localparam logic [5:0] ALL_ZERO_CNT = 6'd61;

    // Stage 0: capture the word alongside the LZD's own register so that in_d_reg
    // and zero_pos describe the same word in the following cycle.
    logic [60:0] in_d_reg;
    logic        v0_reg;

    logic [60:0] norm_reg;
    logic [5:0]  lz_reg;
    logic        zero_flag_reg;
    logic        valid_reg;

    // Stage-0 register: clears on reset and otherwise loads every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_d_reg <= '0;
            v0_reg   <= 1'b0;
        end else begin
            in_d_reg <= in;
            v0_reg   <= en_norm;
        end
    end

`ifdef NORM_PIPELINE_EN

    // Coarse, medium and fine shift stages. The count travels with the data.
    logic [60:0] s1_next;
    logic [60:0] s1_reg;
    logic [5:0]  cnt1_reg;
    logic        v1_reg;

    logic [60:0] s2_next;
    logic [60:0] s2_reg;
    logic [5:0]  cnt2_reg;
    logic        v2_reg;

    logic [60:0] norm_next;

    // Coarse shift by 0/16/32/48. This stage samples zero_pos directly.
    always_comb begin
        s1_next = in_d_reg << {zero_pos[5:4], 4'b0000};
    end

    // Medium shift by 0/4/8/12, using the count carried from stage 1.
    always_comb begin
        s2_next = s1_reg << {cnt1_reg[3:2], 2'b00};
    end

    // Fine shift by 0..3. Each output bit is a 4:1 mux over its lower neighbours,
    // with zeros fed in below bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < 61; gi = gi + 1) begin : g_fine
            logic [3:0] taps;
            assign taps[0] = s2_reg[gi];
            if (gi >= 1) begin : g_t1
                assign taps[1] = s2_reg[gi-1];
            end else begin : g_t1z
                assign taps[1] = 1'b0;
            end
            if (gi >= 2) begin : g_t2
                assign taps[2] = s2_reg[gi-2];
            end else begin : g_t2z
                assign taps[2] = 1'b0;
            end
            if (gi >= 3) begin : g_t3
                assign taps[3] = s2_reg[gi-3];
            end else begin : g_t3z
                assign taps[3] = 1'b0;
            end
            assign norm_next[gi] = taps[cnt2_reg[1:0]];
        end
    endgenerate

    // Shift-stage registers. Data loads every cycle. Only the valid bits matter
    // while the pipeline is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg        <= '0;
            cnt1_reg      <= '0;
            v1_reg        <= 1'b0;
            s2_reg        <= '0;
            cnt2_reg      <= '0;
            v2_reg        <= 1'b0;
            norm_reg      <= '0;
            lz_reg        <= '0;
            zero_flag_reg <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            s1_reg        <= s1_next;
            cnt1_reg      <= zero_pos;
            v1_reg        <= v0_reg;
            s2_reg        <= s2_next;
            cnt2_reg      <= cnt1_reg;
            v2_reg        <= v1_reg;
            norm_reg      <= norm_next;
            lz_reg        <= cnt2_reg;
            zero_flag_reg <= (cnt2_reg == ALL_ZERO_CNT);
            valid_reg     <= v2_reg;
        end
    end

`else

    logic [60:0] norm_next;

    // Full barrel shift in one step. A shift of 61 or more yields 0.
    always_comb begin
        norm_next = in_d_reg << zero_pos;
    end

    // Output register placed directly after stage 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            norm_reg      <= '0;
            lz_reg        <= '0;
            zero_flag_reg <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            norm_reg      <= norm_next;
            lz_reg        <= zero_pos;
            zero_flag_reg <= (zero_pos == ALL_ZERO_CNT);
            valid_reg     <= v0_reg;
        end
    end

`endif

    assign norm_out  = norm_reg;
    assign lz_out    = lz_reg;
    assign zero_flag = zero_flag_reg;
    assign valid_out = valid_reg;

endmodule

// File: tb/tb_lead0_normalize64.sv
// Testbench for lead0_normalize64. The bench plays the role of the LZD: each
// word's leading-zero count is driven one cycle after the word itself.
// Expected outputs come from a table and from an arithmetic reference
// (in << clz(in)), and are scoreboarded per presentation cycle.

module tb_lead0_normalize64;

`ifdef NORM_PIPELINE_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en_norm;
    logic [60:0] in_w;
    logic [5:0]  zero_pos;
    logic [60:0] norm_out;
    logic [5:0]  lz_out;
    logic        zero_flag;
    logic        valid_out;

    always #5 clk = ~clk;

    lead0_normalize64 dut (
        .clk       (clk),
        .rst       (rst),
        .en_norm   (en_norm),
        .in        (in_w),
        .zero_pos  (zero_pos),
        .norm_out  (norm_out),
        .lz_out    (lz_out),
        .zero_flag (zero_flag),
        .valid_out (valid_out)
    );

    typedef struct {
        logic [60:0] w;
        logic [5:0]  zp;
        logic [60:0] xn;
        logic [5:0]  xl;
        logic        xf;
    } vec_t;

    vec_t tbl [9];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [60:0] e_norm [0:1023];
    logic [5:0]  e_lz   [0:1023];
    logic        e_flag [0:1023];
    logic        e_v    [0:1023];
    logic [5:0]  pend_zp  = '0;
    logic        prev_rst = 1'b0;

    function automatic logic [5:0] clz61(input logic [60:0] w);
        for (int i = 60; i >= 0; i--)
            if (w[i]) return 6'(60 - i);
        return 6'd61;
    endfunction

    function automatic logic [60:0] ref_norm(input logic [60:0] w, input logic [5:0] c);
        logic [63:0] t;
        if (c > 6'd61) return '0;
        t = {3'b000, w} << c;
        return t[60:0];
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Check the outputs produced by the edge just before this negedge.
    task automatic check_outputs();
        int j;
        if (prev_rst) begin
            cmp("rst_norm",  64'(norm_out),  64'd0);
            cmp("rst_lz",    64'(lz_out),    64'd0);
            cmp("rst_flag",  64'(zero_flag), 64'd0);
            cmp("rst_valid", 64'(valid_out), 64'd0);
        end else begin
            j = cyc - 1 - DEPTH;
            if (j >= 0) begin
                if (e_v[j]) begin
                    cmp("valid", 64'(valid_out), 64'd1);
                    cmp("norm",  64'(norm_out),  64'(e_norm[j]));
                    cmp("lz",    64'(lz_out),    64'(e_lz[j]));
                    cmp("flag",  64'(zero_flag), 64'(e_flag[j]));
                    if (!e_flag[j] && e_lz[j] <= 6'd61)
                        cmp("msb", 64'(norm_out[60]), 64'd1);
                    $display("beat word=%0d lz=%0d norm=%0h flag=%0b", j, lz_out, norm_out, zero_flag);
                end else begin
                    cmp("idle_valid", 64'(valid_out), 64'd0);
                end
            end
        end
    endtask

    // One clock of stimulus. zp is this word's count; it is driven next cycle.
    task automatic step(input logic r, input logic e, input logic [60:0] w, input logic [5:0] zp,
                        input logic [60:0] xn, input logic [5:0] xl, input logic xf);
        @(negedge clk);
        check_outputs();
        rst      = r;
        en_norm  = e;
        in_w     = w;
        zero_pos = pend_zp;
        pend_zp  = zp;
        e_norm[cyc] = xn;
        e_lz[cyc]   = xl;
        e_flag[cyc] = xf;
        e_v[cyc]    = e && !r;
        if (r)
            for (int k = cyc - DEPTH; k <= cyc; k++)
                if (k >= 0) e_v[k] = 1'b0;
        prev_rst = r;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic rnd_word(input logic r, input logic e);
        logic [63:0] rv;
        logic [60:0] w;
        logic [5:0]  c;
        rv = {$urandom, $urandom};
        rv = rv >> $urandom_range(0, 63);
        w  = rv[60:0];
        if ($urandom_range(0, 15) == 0) w = '0;
        c = clz61(w);
        step(r, e, w, c, ref_norm(w, c), c, c == 6'd61);
    endtask

    initial begin
        tbl[0] = '{61'h1000_0000_0000_0000, 6'd0,  61'h1000_0000_0000_0000, 6'd0,  1'b0};
        tbl[1] = '{61'h0000_0000_0000_0001, 6'd60, 61'h1000_0000_0000_0000, 6'd60, 1'b0};
        tbl[2] = '{61'h0,                   6'd61, 61'h0,                   6'd61, 1'b1};
        tbl[3] = '{61'h0000_0000_0000_0003, 6'd59, 61'h1800_0000_0000_0000, 6'd59, 1'b0};
        tbl[4] = '{61'h0800_0000_0000_0001, 6'd1,  61'h1000_0000_0000_0002, 6'd1,  1'b0};
        tbl[5] = '{61'h0000_8000_0000_0000, 6'd13, 61'h1000_0000_0000_0000, 6'd13, 1'b0};
        tbl[6] = '{61'h1FFF_FFFF_FFFF_FFFF, 6'd63, 61'h0,                   6'd63, 1'b0};
        tbl[7] = '{61'h0000_0000_0000_00F0, 6'd62, 61'h0,                   6'd62, 1'b0};
        tbl[8] = '{61'h1FFF_FFFF_FFFF_FFFF, 6'd0,  61'h1FFF_FFFF_FFFF_FFFF, 6'd0,  1'b0};

        rst = 1'b1; en_norm = 1'b0; in_w = '0; zero_pos = '0;

        // Initial reset, then a cycle that checks the cleared outputs.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        idle();

        // Directed vectors, back to back.
        for (int i = 0; i < 9; i++)
            step(1'b0, 1'b1, tbl[i].w, tbl[i].zp, tbl[i].xn, tbl[i].xl, tbl[i].xf);
        for (int i = 0; i < 3; i++) idle();

        // Random stream with en toggled pseudo-randomly.
        for (int i = 0; i < 200; i++) rnd_word(1'b0, $urandom_range(0, 3) != 0);

        // Mid-stream reset with three words in flight, then a word right after.
        for (int i = 0; i < 3; i++) rnd_word(1'b0, 1'b1);
        rnd_word(1'b1, 1'b1);
        rnd_word(1'b0, 1'b1);
        rnd_word(1'b0, 1'b1);

        // Drain the pipeline so every presented word gets checked.
        for (int i = 0; i < DEPTH + 3; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
